// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fixed-latency FPU between two requesters.
// Operands are registered at grant; the FPU result is captured LAT cycles later.
module fpu_arbiter #(
    parameter int unsigned LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [1:0]  fpu_ctrl,
    input  logic [31:0] fpu_result,
    output logic        busy
);

    localparam logic [3:0] CntLast = 4'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StResp} stateT;

    stateT       stateQ, stateD;
    logic        ptrQ, ptrD;
    logic        grantQ, grantD;
    logic [3:0]  cntQ, cntD;
    logic [31:0] opAQ, opAD;
    logic [31:0] opBQ, opBD;
    logic [1:0]  opCtrlQ, opCtrlD;
    logic [31:0] respDataQ, respDataD;
    logic        grantSel;
    logic        respAck;

    always_comb begin
        stateD     = stateQ;
        ptrD       = ptrQ;
        grantD     = grantQ;
        cntD       = cntQ;
        opAD       = opAQ;
        opBD       = opBQ;
        opCtrlD    = opCtrlQ;
        respDataD  = respDataQ;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        // The pointer only matters on contention; a lone requester always wins.
        grantSel   = (req0_valid && req1_valid) ? ptrQ : req1_valid;
        respAck    = grantQ ? resp1_ready : resp0_ready;

        case (stateQ)
            StIdle: begin
                if ((req0_valid || req1_valid) && !reset) begin
                    req0_ready = !grantSel;
                    req1_ready = grantSel;
                    grantD     = grantSel;
                    opAD       = grantSel ? req1_a  : req0_a;
                    opBD       = grantSel ? req1_b  : req0_b;
                    opCtrlD    = grantSel ? req1_op : req0_op;
                    cntD       = 4'd0;
                    stateD     = StExec;
                end
            end
            StExec: begin
                cntD = cntQ + 4'd1;
                if (cntQ == CntLast) begin
                    respDataD = fpu_result;
                    stateD    = StResp;
                end
            end
            StResp: begin
                if (respAck) begin
                    ptrD   = !grantQ;
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            ptrQ      <= 1'b0;
            grantQ    <= 1'b0;
            cntQ      <= 4'd0;
            opAQ      <= 32'd0;
            opBQ      <= 32'd0;
            opCtrlQ   <= 2'd0;
            respDataQ <= 32'd0;
        end else begin
            stateQ    <= stateD;
            ptrQ      <= ptrD;
            grantQ    <= grantD;
            cntQ      <= cntD;
            opAQ      <= opAD;
            opBQ      <= opBD;
            opCtrlQ   <= opCtrlD;
            respDataQ <= respDataD;
        end
    end

    assign resp0_valid = (stateQ == StResp) && !grantQ;
    assign resp1_valid = (stateQ == StResp) && grantQ;
    assign resp_data   = respDataQ;
    assign fpu_a       = opAQ;
    assign fpu_b       = opBQ;
    assign fpu_ctrl    = opCtrlQ;
    assign busy        = (stateQ != StIdle);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Bench for fpu_arbiter: three builds (LAT 2, 1, 15) share one stimulus stream and
// are each tracked by a transaction-level model; directed scenarios target the LAT=2 build.
module tb_fpu_arbiter;

    localparam int NInst = 3;
    localparam int unsigned LATS [NInst] = '{2, 1, 15};

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid, resp0_ready, resp1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;

    logic [NInst-1:0] rdy0, rdy1, rv0, rv1, busyV;
    logic [31:0] rData [NInst];
    logic [31:0] fA    [NInst];
    logic [31:0] fB    [NInst];
    logic [31:0] fRes  [NInst];
    logic [1:0]  fCtrl [NInst];

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    // Stand-in FPU: exact results for the known vectors, a keyed mix otherwise.
    function automatic logic [31:0] fpuStub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] ctrl);
        if (ctrl == 2'b01 && a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        if (ctrl == 2'b00 && a == 32'h0000_3C00 && b == 32'h0000_3C00) return 32'h0000_4000;
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E37_79B9 * 32'(ctrl) + 32'd1;
    endfunction

    for (genvar gi = 0; gi < NInst; gi++) begin : gInst
        assign fRes[gi] = fpuStub(fA[gi], fB[gi], fCtrl[gi]);
        fpu_arbiter #(.LAT(LATS[gi])) uDut (
            .clk        (clk),
            .reset      (reset),
            .req0_valid (req0_valid),
            .req0_ready (rdy0[gi]),
            .req0_a     (req0_a),
            .req0_b     (req0_b),
            .req0_op    (req0_op),
            .req1_valid (req1_valid),
            .req1_ready (rdy1[gi]),
            .req1_a     (req1_a),
            .req1_b     (req1_b),
            .req1_op    (req1_op),
            .resp0_valid(rv0[gi]),
            .resp0_ready(resp0_ready),
            .resp1_valid(rv1[gi]),
            .resp1_ready(resp1_ready),
            .resp_data  (rData[gi]),
            .fpu_a      (fA[gi]),
            .fpu_b      (fB[gi]),
            .fpu_ctrl   (fCtrl[gi]),
            .fpu_result (fRes[gi]),
            .busy       (busyV[gi])
        );
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Transaction-level model: a grant at cycle g yields a response from g+LAT+1 until acked.
    bit          mBusy      [NInst];
    bit          mServed    [NInst];
    bit          mPtr       [NInst];
    int          mRespStart [NInst];
    logic [31:0] mData      [NInst];
    logic [31:0] mShown     [NInst];
    logic [31:0] mA         [NInst];
    logic [31:0] mB         [NInst];
    logic [1:0]  mCtrl      [NInst];
    bit          started = 1'b0;
    int          cyc = 0;

    always @(negedge clk) begin
        for (int k = 0; k < NInst; k++) begin
            bit    grantNow;
            bit    g;
            bit    inResp;
            string p;
            p        = $sformatf("L%0d", LATS[k]);
            grantNow = !mBusy[k] && !reset && (req0_valid || req1_valid);
            g        = (req0_valid && req1_valid) ? mPtr[k] : req1_valid;
            inResp   = mBusy[k] && (cyc >= mRespStart[k]);
            if (inResp) mShown[k] = mData[k];
            if (started) begin
                checkVal({p, " req0_ready"}, 32'(rdy0[k]), 32'(grantNow && !g));
                checkVal({p, " req1_ready"}, 32'(rdy1[k]), 32'(grantNow && g));
                checkVal({p, " resp0_valid"}, 32'(rv0[k]), 32'(inResp && !mServed[k]));
                checkVal({p, " resp1_valid"}, 32'(rv1[k]), 32'(inResp && mServed[k]));
                checkVal({p, " busy"}, 32'(busyV[k]), 32'(mBusy[k]));
                checkVal({p, " fpu_a"}, fA[k], mA[k]);
                checkVal({p, " fpu_b"}, fB[k], mB[k]);
                checkVal({p, " fpu_ctrl"}, 32'(fCtrl[k]), 32'(mCtrl[k]));
                checkVal({p, " resp_data"}, rData[k], mShown[k]);
            end
            if (reset) begin
                mBusy[k] = 1'b0; mServed[k] = 1'b0; mPtr[k] = 1'b0; mRespStart[k] = 0;
                mData[k] = '0; mShown[k] = '0; mA[k] = '0; mB[k] = '0; mCtrl[k] = '0;
            end else if (grantNow) begin
                mBusy[k]      = 1'b1;
                mServed[k]    = g;
                mRespStart[k] = cyc + int'(LATS[k]) + 1;
                mA[k]         = g ? req1_a : req0_a;
                mB[k]         = g ? req1_b : req0_b;
                mCtrl[k]      = g ? req1_op : req0_op;
                mData[k]      = fpuStub(mA[k], mB[k], mCtrl[k]);
            end else if (inResp && (mServed[k] ? resp1_ready : resp0_ready)) begin
                mBusy[k] = 1'b0;
                mPtr[k]  = !mServed[k];
            end
        end
        if (reset) started = 1'b1;
        cyc++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle;
        bit done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = !busyV[0];
            tick();
        end
        checkVal("wait_idle", 32'(done), 32'd1);
    endtask

    initial begin
        bit found;
        int nGrants, prevCyc;
        logic [31:0] held;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0; req0_op = '0; req1_op = '0;
        tick(); tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checkVal("rst_ready", {30'd0, rdy0[0], rdy1[0]}, 32'd0);
        checkVal("rst_busy", 32'(busyV[0]), 32'd0);
        checkVal("rst_data", rData[0], 32'd0);
        tick();
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        tick();

        // add32 1.0 + 1.0 from requester 0
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h3F80_0000; req0_op = 2'b01;
        @(negedge clk);
        checkVal("add32_grant", 32'(rdy0[0]), 32'd1);
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkVal("add32_early", 32'(rv0[0]), 32'd0);
            tick();
        end
        @(negedge clk);
        checkVal("add32_valid", 32'(rv0[0]), 32'd1);
        checkVal("add32_data", rData[0], 32'h4000_0000);
        tick();

        // add16 1.0 + 1.0 from requester 1
        req1_valid = 1'b1; req1_a = 32'h0000_3C00; req1_b = 32'h0000_3C00; req1_op = 2'b00;
        @(negedge clk);
        checkVal("add16_grant", 32'(rdy1[0]), 32'd1);
        tick();
        req1_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            checkVal("add16_no_resp0", 32'(rv0[0]), 32'd0);
            if (rv1[0]) begin
                found = 1'b1;
                checkVal("add16_data", rData[0], 32'h0000_4000);
            end
            tick();
        end
        checkVal("add16_seen", 32'(found), 32'd1);

        // Both requesters valid continuously: strict alternation at LAT+2 spacing
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = $urandom; req0_b = $urandom; req0_op = 2'b11;
        req1_a = $urandom; req1_b = $urandom; req1_op = 2'b10;
        nGrants = 0; prevCyc = 0;
        for (int c = 0; c < 60 && nGrants < 8; c++) begin
            @(negedge clk);
            if (rdy0[0] || rdy1[0]) begin
                checkVal("rr_order", 32'(rdy1[0]), 32'(nGrants % 2));
                if (nGrants > 0) checkVal("rr_gap", 32'(c - prevCyc), LATS[0] + 2);
                prevCyc = c;
                nGrants++;
            end
            tick();
        end
        checkVal("rr_count", 32'(nGrants), 32'd8);
        req0_valid = 1'b0; req1_valid = 1'b0;
        waitIdle();

        // Response back-pressure: requester 0 holds resp0_ready low
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 2'b10;
        resp0_ready = 1'b0;
        @(negedge clk);
        checkVal("hold_grant", 32'(rdy0[0]), 32'd1);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            found = rv0[0];
            if (!found) tick();
        end
        checkVal("hold_seen", 32'(found), 32'd1);
        held = rData[0];
        for (int i = 0; i < 5; i++) begin
            checkVal("hold_valid", 32'(rv0[0]), 32'd1);
            checkVal("hold_data", rData[0], held);
            checkVal("hold_busy", 32'(busyV[0]), 32'd1);
            checkVal("hold_no_ready", {30'd0, rdy0[0], rdy1[0]}, 32'd0);
            tick();
            @(negedge clk);
        end
        tick();
        resp0_ready = 1'b1;
        @(negedge clk);
        checkVal("hold_last_valid", 32'(rv0[0]), 32'd1);
        tick();
        @(negedge clk);
        checkVal("hold_idle", 32'(busyV[0]), 32'd0);
        checkVal("hold_next_grant", 32'(rdy1[0]), 32'd1);
        tick();
        req1_valid = 1'b0; resp1_ready = 1'b1;
        waitIdle();

        // Reset in the first EXEC cycle aborts, then requester 0 wins on contention
        req0_valid = 1'b1; req0_a = $urandom; req0_b = $urandom; req0_op = 2'b01;
        @(negedge clk);
        checkVal("abort_grant", 32'(rdy0[0]), 32'd1);
        tick();
        reset = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        checkVal("abort_rst_ready", {30'd0, rdy0[0], rdy1[0]}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkVal("abort_busy", 32'(busyV[0]), 32'd0);
        checkVal("abort_resp", {30'd0, rv0[0], rv1[0]}, 32'd0);
        checkVal("abort_fpu_a", fA[0], 32'd0);
        checkVal("abort_fpu_ctrl", 32'(fCtrl[0]), 32'd0);
        checkVal("abort_data", rData[0], 32'd0);
        checkVal("abort_first_grant", {30'd0, rdy0[0], rdy1[0]}, 32'd2);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomized traffic, including occasional resets, checked by the model
        for (int n = 0; n < 2500; n++) begin
            req0_valid  = ($urandom_range(0, 99) < 55);
            req1_valid  = ($urandom_range(0, 99) < 55);
            resp0_ready = ($urandom_range(0, 99) < 70);
            resp1_ready = ($urandom_range(0, 99) < 70);
            reset       = ($urandom_range(0, 299) == 0);
            req0_a = $urandom; req0_b = $urandom; req0_op = 2'($urandom_range(0, 3));
            req1_a = $urandom; req1_b = $urandom; req1_op = 2'($urandom_range(0, 3));
            tick();
        end
        reset = 1'b0;
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
